// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Hazard / stall / flush sequencer for the IF and ID stages.
//            Resolves load-use hazards, taken-branch redirects, external
//            data-memory stalls and HI/LO hazards against a multi-cycle
//            mult/div unit.
//
//            The mult/div unit is tracked by a two-state busy FSM with a
//            countdown. All control outputs are combinational, so a decision
//            takes effect in the same cycle that it is made.
// Ports    : clk, rst_n (async, active-low)
//            i_ifid_*  - operand and class info for the instruction in ID
//            i_idex_*  - load info for the instruction in EX
//            i_branch_taken, i_ext_stall
//            o_pc_we, o_ifid_we, o_ifid_flush, o_idex_flush
//            o_md_issue, o_md_busy, o_perf_stall_cycles, o_perf_flushes
// Options  : HAZARD_PERF_EN - when defined, enables the saturating
//            stall-cycle and branch-flush counters. When it is not defined,
//            both perf outputs are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] i_ifid_rs,
  input  logic [REG_ADDR_W-1:0] i_ifid_rt,
  input  logic                  i_ifid_uses_rt,
  input  logic                  i_ifid_is_md,
  input  logic                  i_ifid_reads_hilo,
  input  logic                  i_idex_mem_read,
  input  logic [REG_ADDR_W-1:0] i_idex_rt,
  input  logic                  i_branch_taken,
  input  logic                  i_ext_stall,
  output logic                  o_pc_we,
  output logic                  o_ifid_we,
  output logic                  o_ifid_flush,
  output logic                  o_idex_flush,
  output logic                  o_md_issue,
  output logic                  o_md_busy,
  output logic [31:0]           o_perf_stall_cycles,
  output logic [31:0]           o_perf_flushes
);

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  localparam logic [CNT_W-1:0] C_MD_LAT = CNT_W'(MD_LATENCY);
  localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

  md_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic             w_load_use;
  logic             w_md_hazard;

  // The r0 check matters: a load to r0 writes nothing, so an instruction
  // that reads r0 does not depend on it.
  assign w_load_use  = i_idex_mem_read && (i_idex_rt != '0) &&
                       ((i_idex_rt == i_ifid_rs) ||
                        (i_ifid_uses_rt && (i_idex_rt == i_ifid_rt)));
  // An mult/div in ID while the unit is busy also stalls. This rule is what
  // prevents a back-to-back issue.
  assign w_md_hazard = (r_state == MD_BUSY) && (i_ifid_reads_hilo || i_ifid_is_md);
  assign o_md_busy   = (r_state == MD_BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MD_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    o_pc_we      = 1'b1;
    o_ifid_we    = 1'b1;
    o_ifid_flush = 1'b0;
    o_idex_flush = 1'b0;
    o_md_issue   = 1'b0;
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;

    // Control outputs, highest priority first. While reset is held, the
    // pipeline is frozen and both stage registers are cleared.
    if (!rst_n) begin
      o_pc_we      = 1'b0;
      o_ifid_we    = 1'b0;
      o_ifid_flush = 1'b1;
      o_idex_flush = 1'b1;
    end else if (i_ext_stall) begin
      // Full freeze. A taken branch stays pending in EX until the stall clears.
      o_pc_we   = 1'b0;
      o_ifid_we = 1'b0;
    end else if (i_branch_taken) begin
      o_ifid_flush = 1'b1;
      o_idex_flush = 1'b1;
    end else if (w_load_use || w_md_hazard) begin
      o_pc_we      = 1'b0;
      o_ifid_we    = 1'b0;
      o_idex_flush = 1'b1;
    end else begin
      o_md_issue = i_ifid_is_md;
    end

    // The mult/div unit free-runs, so it keeps counting through external stalls.
    case (r_state)
      MD_IDLE: begin
        if (o_md_issue) begin
          w_state_nxt = MD_BUSY;
          w_count_nxt = C_MD_LAT;
        end
      end
      MD_BUSY: begin
        w_count_nxt = r_count - C_ONE;
        if (r_count == C_ONE) begin
          w_state_nxt = MD_IDLE;
        end
      end
      default: begin
        w_state_nxt = MD_IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (!o_pc_we && (r_perf_stall != 32'hFFFF_FFFF)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
      if (i_branch_taken && !i_ext_stall && (r_perf_flush != 32'hFFFF_FFFF)) begin
        r_perf_flush <= r_perf_flush + 32'd1;
      end
    end
  end

  assign o_perf_stall_cycles = r_perf_stall;
  assign o_perf_flushes      = r_perf_flush;
`else
  assign o_perf_stall_cycles = 32'd0;
  assign o_perf_flushes      = 32'd0;
`endif

endmodule
`default_nettype wire
